// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - borrow_in, one bit per clock, LSB first.
// A start/busy/done handshake lets a sequencer issue operations and collect results.
// A single full-subtractor cell is reused for WIDTH cycles per operation.
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DONE_S = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sa_q, sa_d;
  logic [WIDTH-1:0]  sb_q, sb_d;
  logic [WIDTH-1:0]  sd_q, sd_d;
  logic              br_q, br_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_q, borrow_d;

  // Full-subtractor cell acting on the current LSBs
  logic             bit_a, bit_b, bit_d, br_nx;
  logic [WIDTH-1:0] sd_nx;

  // Next-state, datapath shift and result capture
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sd_d     = sd_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    bit_a = sa_q[0];
    bit_b = sb_q[0];
    bit_d = bit_a ^ bit_b ^ br_q;
    br_nx = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
    sd_nx = {bit_d, sd_q[WIDTH-1:1]};

    case (state_q)
      IDLE, DONE_S: begin
        if (start) begin
          // Accept: latch operands; a start seen during RUN never gets here
          sa_d    = A;
          sb_d    = B;
          br_d    = borrow_in;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE_S) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        sd_d  = sd_nx;
        br_d  = br_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Last bit: publish the result that includes this bit
          diff_d   = sd_nx;
          borrow_d = br_nx;
          cnt_d    = '0;
          state_d  = DONE_S;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset (reset aborts any op)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sd_q     <= sd_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  // busy/done are decoded straight from the state register, so they are glitch-free
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE_S);
  assign Diff   = diff_q;
  assign Borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor (WIDTH=32).
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        reset, start, borrow_in;
  logic [31:0] A, B;
  logic        busy, done, Borrow;
  logic [31:0] Diff;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .borrow_in(borrow_in),
    .busy(busy), .done(done), .Diff(Diff), .Borrow(Borrow)
  );

  always #5 clk = ~clk;

  // Present operands, let one edge accept them, then wait (bounded) for done.
  // n = edges after the accept edge until done is seen; bc = cycles with busy high.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bi,
                       output int n, output int bc);
    A = a; B = b; borrow_in = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    bc = busy ? 1 : 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; A = '0; B = '0; borrow_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, Borrow, Diff} !== 35'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b Borrow=%b Diff=%h, required all 0", busy, done, Borrow, Diff);
    end
  endtask

  task automatic test_basic();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic        vbi[5];
    logic [31:0] ed [5];
    logic        eb [5];
    int n, bc;
    va[0]=32'd10;        vb[0]=32'd3;         vbi[0]=0; ed[0]=32'd7;          eb[0]=0;
    va[1]=32'd3;         vb[1]=32'd10;        vbi[1]=0; ed[1]=32'hFFFFFFF9;   eb[1]=1;
    va[2]=32'd0;         vb[2]=32'd0;         vbi[2]=1; ed[2]=32'hFFFFFFFF;   eb[2]=1;
    va[3]=32'hFFFFFFFF;  vb[3]=32'hFFFFFFFF;  vbi[3]=0; ed[3]=32'd0;          eb[3]=0;
    va[4]=32'h80000000;  vb[4]=32'd1;         vbi[4]=0; ed[4]=32'h7FFFFFFF;   eb[4]=0;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vbi[i], n, bc);
      checks++;
      if (n !== 32) begin
        errors++;
        $display("FAIL basic%0d latency: got %0d edges, required 32", i, n);
      end
      checks++;
      if (bc !== 32) begin
        errors++;
        $display("FAIL basic%0d busy_cycles: got %0d, required 32", i, bc);
      end
      checks++;
      if ({Borrow, Diff} !== {eb[i], ed[i]}) begin
        errors++;
        $display("FAIL basic%0d result: Borrow=%b Diff=%h, required Borrow=%b Diff=%h",
                 i, Borrow, Diff, eb[i], ed[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL basic%0d done_pulse: done=%b one cycle later, required 0", i, done);
      end
    end
  endtask

  task automatic test_ignore_start();
    int n;
    A = 32'd100; B = 32'd1; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    A = 32'd5; B = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL ignore_start timeout: done never seen");
    end
    checks++;
    if ({Borrow, Diff} !== {1'b0, 32'd99}) begin
      errors++;
      $display("FAIL ignore_start result: Borrow=%b Diff=%0d, required 0/99", Borrow, Diff);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start no_requeue: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_abort();
    int n, bc, seen;
    A = 32'd50; B = 32'd20; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, Borrow, Diff} !== 35'd0) begin
      errors++;
      $display("FAIL abort state: busy=%b done=%b Borrow=%b Diff=%h, required all 0", busy, done, Borrow, Diff);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort no_done: saw %0d done cycles, required 0", seen);
    end
    do_op(32'd50, 32'd20, 1'b0, n, bc);
    checks++;
    if (n !== 32 || {Borrow, Diff} !== {1'b0, 32'd30}) begin
      errors++;
      $display("FAIL abort restart: n=%0d Borrow=%b Diff=%0d, required n=32 0/30", n, Borrow, Diff);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    A = 32'd9; B = 32'd4; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 32'd7; B = 32'd2;  // start stays high through RUN and into DONE
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done || Diff !== 32'd5 || Borrow !== 1'b0) begin
      errors++;
      $display("FAIL b2b first: done=%b Borrow=%b Diff=%0d, required 1 0/5", done, Borrow, Diff);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b reaccept: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 33) begin
      errors++;
      $display("FAIL b2b spacing: done %0d cycles apart, required 33", n);
    end
    checks++;
    if ({Borrow, Diff} !== {1'b0, 32'd5}) begin
      errors++;
      $display("FAIL b2b second: Borrow=%b Diff=%0d, required 0/5", Borrow, Diff);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        bi;
    logic [32:0] exp;
    int n, bc;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom; bi = 1'($urandom_range(0, 1));
      if (i % 7 == 0) b = a;
      exp = {1'b0, a} - {1'b0, b} - {32'd0, bi};
      do_op(a, b, bi, n, bc);
      checks++;
      if (n !== 32 || {Borrow, Diff} !== exp) begin
        errors++;
        $display("FAIL random%0d: A=%h B=%h bi=%b got n=%0d Borrow=%b Diff=%h, required n=32 Borrow=%b Diff=%h",
                 i, a, b, bi, n, Borrow, Diff, exp[32], exp[31:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
